fft_stage_ctrl: RTL
===================

// Module: fft_stage_ctrl
// PURPOSE
//  Sequencer for the 16-lane radix-2 butterfly datapath of the 512-point FFT.
//  Loads one frame (DATA/NUM beats) into the ping-pong buffer, then issues log2(DATA) butterfly passes from it.
//  Per pass: drives butterfly valid, beat index, twiddle address and bank selects, and counts returned results.
//  Sits between the input sample source, the ping-pong buffer and the butterfly.
// PARAMETERS
//  NUM     16   lanes per beat
//  DATA    512  points per frame; BEATS=DATA/NUM=32, STAGES=$clog2(DATA)=9 (localparams)
//  BF_LAT  2    butterfly valid_in->valid_out latency, cycles (used only by the bench and for the timeout base)
//  TMO     64   max DRAIN cycles before timeout
//  TW_AW   8    twiddle ROM address width (DATA/2 entries)
// PORTS
//  clk           in   1        clock
//  rstn          in   1        async active-low reset
//  start         in   1        frame request; sampled in IDLE only
//  src_valid     in   1        input beat valid
//  in_ready      out  1        ctrl accepts input beat (LOAD only)
//  bf_valid_in   out  1        issue beat to butterfly
//  bf_valid_out  in   1        butterfly result beat valid
//  beat_idx      out  5        beat being loaded/issued
//  out_beat_idx  out  5        beat index of the current bf_valid_out
//  stage_idx     out  4        current pass 0..STAGES-1
//  tw_addr       out  TW_AW    twiddle base address for lane 0
//  buf_rd_bank   out  1        buffer bank read by the butterfly
//  buf_wr_bank   out  1        buffer bank written (load or results)
//  busy          out  1        state != IDLE
//  stage_done    out  1        1-cycle pulse per completed pass
//  frame_done    out  1        1-cycle pulse after the last pass
//  err_overrun   out  1        sticky: unexpected bf_valid_out
//  err_timeout   out  1        sticky: DRAIN exceeded TMO
// BEHAVIOUR
//  Reset (async, rstn=0): state=IDLE; every output and counter=0, including both bank selects and both error flags.
//  A reset in any state aborts the frame immediately; no done pulse is produced.
//  FSM: IDLE -> LOAD -> RUN -> DRAIN -> (RUN | DONE) -> IDLE.
//  IDLE:
//   - start=1: clear beat_idx, stage_idx, out_beat_idx and both err flags; go to LOAD.
//   - start in any other state is ignored.
//  LOAD:
//   - in_ready=1, buf_wr_bank=0.
//   - A beat is accepted when src_valid&in_ready; beat_idx increments per accepted beat only, so gaps are allowed.
//   - Acceptance of beat 31 -> RUN with stage_idx=0, beat_idx=0.
//  RUN:
//   - bf_valid_in=1 every cycle; beat_idx 0..31.
//   - buf_rd_bank=stage_idx[0], buf_wr_bank=~stage_idx[0].
//   - tw_addr=({beat_idx,4'b0}<<stage_idx) mod 2^TW_AW.
//   - Issue of beat 31 -> DRAIN, beat_idx=0.
//  DRAIN:
//   - bf_valid_in=0. A timeout counter runs from DRAIN entry.
//  Result counting (RUN and DRAIN):
//   - Each bf_valid_out increments out_beat_idx; out_beat_idx is the index of that beat.
//   - When the 32nd result of the pass is sampled, out_beat_idx wraps to 0.
//   - Next cycle: stage_done=1 and stage_idx increments. Go to RUN, or to DONE if stage_idx was STAGES-1.
//   - Pass period is 33+BF_LAT cycles.
//  DONE: frame_done=1 for one cycle -> IDLE. After 9 passes the result is in bank 1.
//  err_overrun: set when bf_valid_out=1 and the outstanding issued-minus-returned count is 0, or in IDLE/LOAD.
//   - Offending beat is not counted; FSM continues.
//  err_timeout: set when the DRAIN counter reaches TMO. FSM goes to IDLE; no done pulse.
//  Outstanding count width is 6 bits; it never exceeds 32.
//  Simultaneous issue and return in one cycle: count unchanged.
// TESTING
//  1. Reset mid-RUN (stage 3, beat 10): all outputs 0 asynchronously; busy=0; no frame_done after release.
//  2. start, 32 src_valid beats back-to-back, ideal butterfly BF_LAT=2:
//     - in_ready high exactly 32 cycles.
//     - 9 stage_done pulses spaced 35 cycles, then one frame_done; buf_rd_bank sequence 0,1,0,...,0.
//  3. src_valid toggling 1/0 during LOAD: 64 LOAD cycles; beat_idx advances only on accepted beats; RUN starts after beat 31.
//  4. tw_addr check: stage 0 beat 1 -> 16; stage 2 beat 3 -> 192; stage 4 beat 1 -> 0 (wrap).
//  5. Butterfly model that drops the last result: err_timeout=1 64 cycles after DRAIN entry; state IDLE; frame_done never asserted.
//  6. Extra bf_valid_out injected in LOAD: err_overrun=1 and stays 1; next start clears it; frame otherwise completes normally.

Source files
------------

// File: rtl/fft_stage_ctrl.sv
// Pass sequencer for the radix-2 FFT butterfly: loads one frame into the ping-pong
// buffer, then issues STAGES butterfly passes and tracks the returned results.
module fft_stage_ctrl #(
   parameter int NUM    = 16,
   parameter int DATA   = 512,
   parameter int BF_LAT = 2,
   parameter int TMO    = 64,
   parameter int TW_AW  = 8
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             start,
   input  logic             src_valid,
   output logic             in_ready,
   output logic             bf_valid_in,
   input  logic             bf_valid_out,
   output logic [4:0]       beat_idx,
   output logic [4:0]       out_beat_idx,
   output logic [3:0]       stage_idx,
   output logic [TW_AW-1:0] tw_addr,
   output logic             buf_rd_bank,
   output logic             buf_wr_bank,
   output logic             busy,
   output logic             stage_done,
   output logic             frame_done,
   output logic             err_overrun,
   output logic             err_timeout
);

   localparam int BEATS  = DATA / NUM;
   localparam int STAGES = $clog2(DATA);
   localparam int LW     = $clog2(NUM);
   localparam int TCW    = $clog2(TMO + BF_LAT + 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_RUN   = 3'd2,
      S_DRAIN = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t           state, state_nxt;
   logic [5:0]       outst;
   logic [TCW-1:0]   tmo_cnt;
   logic             pass_end;
   logic             issue, acc, ovr, tmo_hit, last_beat, last_stage;
   logic [TW_AW-1:0] tw_base;

   assign issue      = (state == S_RUN);
   // A return is only legitimate while a pass is active and something is in flight.
   assign acc        = bf_valid_out && (state == S_RUN || state == S_DRAIN) && (outst != 6'd0);
   assign ovr        = bf_valid_out && !acc;
   assign tmo_hit    = (tmo_cnt == TCW'(TMO - 1));
   assign last_beat  = (beat_idx == 5'(BEATS - 1));
   assign last_stage = (stage_idx == 4'(STAGES - 1));

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state <= S_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (start) state_nxt = S_LOAD;
         S_LOAD:  if (src_valid && last_beat) state_nxt = S_RUN;
         S_RUN:   if (last_beat) state_nxt = S_DRAIN;
         S_DRAIN: begin
            if (pass_end)     state_nxt = last_stage ? S_DONE : S_RUN;
            else if (tmo_hit) state_nxt = S_IDLE;
         end
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      in_ready    = (state == S_LOAD);
      bf_valid_in = (state == S_RUN);
      busy        = (state != S_IDLE);
      stage_done  = (state == S_DRAIN) && pass_end;
      frame_done  = (state == S_DONE);
      buf_rd_bank = 1'b0;
      buf_wr_bank = 1'b0;
      tw_addr     = '0;
      tw_base     = TW_AW'({beat_idx, {LW{1'b0}}});
      if (state == S_RUN || state == S_DRAIN) begin
         buf_rd_bank = stage_idx[0];
         buf_wr_bank = ~stage_idx[0];
      end
      // Truncating before the shift is the same as taking the product mod 2^TW_AW.
      if (state == S_RUN) tw_addr = tw_base << stage_idx;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         beat_idx     <= '0;
         out_beat_idx <= '0;
         stage_idx    <= '0;
         outst        <= '0;
         tmo_cnt      <= '0;
         pass_end     <= 1'b0;
         err_overrun  <= 1'b0;
         err_timeout  <= 1'b0;
      end else begin
         case (state)
            S_IDLE: if (start) begin
               beat_idx     <= '0;
               out_beat_idx <= '0;
               stage_idx    <= '0;
               outst        <= '0;
               tmo_cnt      <= '0;
               pass_end     <= 1'b0;
               err_overrun  <= 1'b0;
               err_timeout  <= 1'b0;
            end
            S_LOAD: if (src_valid) beat_idx <= beat_idx + 5'd1;
            S_RUN: begin
               beat_idx <= beat_idx + 5'd1;
               tmo_cnt  <= '0;
            end
            S_DRAIN: begin
               tmo_cnt <= tmo_cnt + TCW'(1);
               if (pass_end) begin
                  pass_end <= 1'b0;
                  if (!last_stage) stage_idx <= stage_idx + 4'd1;
               end else if (tmo_hit) begin
                  err_timeout <= 1'b1;
               end
            end
            default: ;
         endcase
         // Issue and return in the same cycle cancel out.
         if (state != S_IDLE) outst <= outst + 6'(issue) - 6'(acc);
         if (acc) begin
            out_beat_idx <= out_beat_idx + 5'd1;
            if (out_beat_idx == 5'(BEATS - 1)) pass_end <= 1'b1;
         end
         if (ovr) err_overrun <= 1'b1;
      end
   end

endmodule
